// File: rtl/sm_fetch_queue.sv
// schoolMIPS fetch stage: owns the PC, reads the instruction ROM and buffers {pc, instr} in a FIFO.
// Optional SM_FETCH_BYPASS_EN: an empty queue forwards the ROM word straight to decode.
module sm_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [31:0]              imAddr,
    input  logic [31:0]              imData,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   fq_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [31:0]   pc;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          started;

    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];

    logic          bypass;
    logic          pop;
    logic          fifo_pop;
    logic          push;
    logic          advance;
    logic          unused_bits;

    assign imAddr      = {2'b00, pc[31:2]};
    assign fq_count    = count;
    assign unused_bits = ^{redirect_pc[1:0], started};

    always_comb begin
        bypass    = 1'b0;
`ifdef SM_FETCH_BYPASS_EN
        bypass    = (count == '0) && started && !redirect;
`endif
        out_valid = bypass || (count != '0);
        out_instr = bypass ? imData : q_instr[rd_ptr];
        out_pc    = bypass ? pc     : q_pc[rd_ptr];
        pop       = out_valid && out_ready;
        // A bypassed word never enters the FIFO, so its handshake must not move rd_ptr.
        fifo_pop  = pop && !bypass;
        push      = !redirect && ((count < CNT_FULL) || fifo_pop) && !(bypass && out_ready);
        advance   = push || (bypass && out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            if (redirect) begin
                pc     <= {redirect_pc[31:2], 2'b00};
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (advance)  pc     <= pc + 32'd4;
                if (push)     wr_ptr <= wr_ptr + 1'b1;
                if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
                case ({push, fifo_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= pc;
            q_instr[wr_ptr] <= imData;
        end
    end

endmodule

// File: tb/tb_sm_fetch_queue.sv
// Directed bench for sm_fetch_queue (default build); ROM word i holds 0x1000_0000 + i.
module tb_sm_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imaddr, imdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc;
    logic [2:0]  fq_count;

    logic [31:0] imaddr2, imdata2;
    logic        out_valid2;
    logic [31:0] out_instr2, out_pc2;
    logic [2:0]  fq_count2;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    assign imdata  = 32'h1000_0000 + imaddr;
    assign imdata2 = 32'h1000_0000 + imaddr2;

    sm_fetch_queue #(.DEPTH(4), .RESET_PC(32'h00000000)) dut (
        .clk(clk), .rst_n(rst_n), .imAddr(imaddr), .imData(imdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .fq_count(fq_count)
    );

    sm_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imAddr(imaddr2), .imData(imdata2),
        .redirect(1'b0), .redirect_pc(32'h0),
        .out_valid(out_valid2), .out_ready(1'b1),
        .out_instr(out_instr2), .out_pc(out_pc2), .fq_count(fq_count2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        step(); step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_checks++; if (fq_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fq_count); end
        n_checks++; if (imaddr !== 32'h0) begin n_fail++; $display("FAIL reset_imaddr got %h want 0", imaddr); end
        n_checks++; if (imaddr2 !== 32'h3FFF_FFFF) begin n_fail++; $display("FAIL reset_imaddr_wrap got %h want 3fffffff", imaddr2); end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc = 32'h0;
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %b want 1", i, out_valid); end
            n_checks++; if (out_pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc[%0d] got %h want %h", i, out_pc, exp_pc); end
            n_checks++; if (out_instr !== 32'h1000_0000 + (exp_pc >> 2)) begin n_fail++; $display("FAIL stream_instr[%0d] got %h want %h", i, out_instr, 32'h1000_0000 + (exp_pc >> 2)); end
            n_checks++; if (fq_count !== 3'd1) begin n_fail++; $display("FAIL stream_count[%0d] got %0d want 1", i, fq_count); end
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_backpressure();
        rst_n = 1'b0; out_ready = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (10) step();
        n_checks++; if (fq_count !== 3'd4) begin n_fail++; $display("FAIL bp_count got %0d want 4", fq_count); end
        n_checks++; if (imaddr !== 32'd4) begin n_fail++; $display("FAIL bp_imaddr got %h want 4", imaddr); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL bp_pc[%0d] got %h/%b want %h", i, out_pc, out_valid, 32'(4 * i)); end
            n_checks++; if (out_instr !== 32'h1000_0000 + 32'(i)) begin n_fail++; $display("FAIL bp_instr[%0d] got %h want %h", i, out_instr, 32'h1000_0000 + 32'(i)); end
            n_checks++; if (fq_count !== 3'd4) begin n_fail++; $display("FAIL bp_full_count[%0d] got %0d want 4", i, fq_count); end
            step();
        end
    endtask

    task automatic test_redirect();
        rst_n = 1'b0; out_ready = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        n_checks++; if (fq_count !== 3'd3) begin n_fail++; $display("FAIL redir_pre_count got %0d want 3", fq_count); end
        redirect = 1'b1; redirect_pc = 32'h0000_0043;
        step();
        redirect = 1'b0;
        n_checks++; if (fq_count !== 3'd0) begin n_fail++; $display("FAIL redir_count got %0d want 0", fq_count); end
        n_checks++; if (imaddr !== 32'h10) begin n_fail++; $display("FAIL redir_imaddr got %h want 10", imaddr); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble got %b want 0", out_valid); end
        out_ready = 1'b1;
        step();
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin n_fail++; $display("FAIL redir_target_pc got %h/%b want 40", out_pc, out_valid); end
        n_checks++; if (out_instr !== 32'h1000_0010) begin n_fail++; $display("FAIL redir_target_instr got %h want 10000010", out_instr); end
        step();
        n_checks++; if (out_pc !== 32'h44) begin n_fail++; $display("FAIL redir_next_pc got %h want 44", out_pc); end
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        n_checks++; if (out_valid2 !== 1'b1 || out_pc2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_first_pc got %h/%b want fffffffc", out_pc2, out_valid2); end
        n_checks++; if (out_instr2 !== 32'h4FFF_FFFF) begin n_fail++; $display("FAIL wrap_first_instr got %h want 4fffffff", out_instr2); end
        step();
        n_checks++; if (out_pc2 !== 32'h0) begin n_fail++; $display("FAIL wrap_second_pc got %h want 0", out_pc2); end
        n_checks++; if (out_instr2 !== 32'h1000_0000) begin n_fail++; $display("FAIL wrap_second_instr got %h want 10000000", out_instr2); end
        n_checks++; if (imaddr2 !== 32'h1) begin n_fail++; $display("FAIL wrap_imaddr got %h want 1", imaddr2); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got %b want 0", out_valid); end
        n_checks++; if (fq_count !== 3'd0) begin n_fail++; $display("FAIL areset_count got %0d want 0", fq_count); end
        n_checks++; if (imaddr !== 32'h0) begin n_fail++; $display("FAIL areset_imaddr got %h want 0", imaddr); end
        step();
        rst_n = 1'b1;
        step();
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_fail++; $display("FAIL areset_resume got %h/%b want 0", out_pc, out_valid); end
        step();
        n_checks++; if (out_pc !== 32'h4) begin n_fail++; $display("FAIL areset_next got %h want 4", out_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
